// File: rtl/fetch_width_aggregator.sv
// Packs a serial word stream into groups of 1..FETCH_WIDTH words for the aggregator receiver.
// Define AGG_OVERLAP_EN to accept the first word of the next group in the same cycle as the enq.
module fetch_width_aggregator #(
    parameter int DATA_WIDTH  = 11,
    parameter int FETCH_WIDTH = 5,
    parameter int CNT_WIDTH   = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fifo_valid,
    input  logic [DATA_WIDTH-1:0]             fifo_data,
    output logic                              fifo_ready,
    input  logic                              change_fetch_width,
    input  logic [2:0]                        input_fetch_width,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  width_q, width_d;
    logic [CNT_WIDTH-1:0]  pos_q, pos_d;
    logic [CNT_WIDTH-1:0]  new_width;
    logic [CNT_WIDTH-1:0]  eff_width;
    logic [DATA_WIDTH-1:0] slot_q [FETCH_WIDTH];
    logic [DATA_WIDTH-1:0] slot_d [FETCH_WIDTH];

    function automatic logic [CNT_WIDTH-1:0] clamp_width(input logic [2:0] w);
        if (w == 3'd0)
            return CNT_WIDTH'(1);
        else if (int'(w) > FETCH_WIDTH)
            return CNT_WIDTH'(FETCH_WIDTH);
        else
            return CNT_WIDTH'(w);
    endfunction

    always_comb begin
        new_width = clamp_width(input_fetch_width);
        eff_width = change_fetch_width ? new_width : width_q;
    end

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        pos_d        = pos_q;
        slot_d       = slot_q;
        fifo_ready   = 1'b0;
        receiver_enq = 1'b0;

        if (change_fetch_width)
            width_d = new_width;

        case (state_q)
            FILL: begin
                fifo_ready = rst_n;
                // A width change mid-group throws away the partial group, including any word arriving now.
                if (change_fetch_width && pos_q != '0) begin
                    pos_d = '0;
                    for (int i = 0; i < FETCH_WIDTH; i++)
                        slot_d[i] = '0;
                end else if (fifo_valid && fifo_ready) begin
                    if (pos_q == '0) begin
                        for (int i = 0; i < FETCH_WIDTH; i++)
                            slot_d[i] = '0;
                        slot_d[0] = fifo_data;
                    end else begin
                        for (int i = 0; i < FETCH_WIDTH; i++)
                            if (CNT_WIDTH'(i) == pos_q)
                                slot_d[i] = fifo_data;
                    end
                    if (pos_q == eff_width - CNT_WIDTH'(1)) begin
                        pos_d   = '0;
                        state_d = HOLD;
                    end else begin
                        pos_d = pos_q + CNT_WIDTH'(1);
                    end
                end
            end
            HOLD: begin
                receiver_enq = receiver_full_n;
`ifdef AGG_OVERLAP_EN
                fifo_ready = receiver_full_n & rst_n;
`endif
                if (receiver_enq) begin
                    state_d = FILL;
`ifdef AGG_OVERLAP_EN
                    // The overlapped word opens the next group under the width in force after this cycle.
                    if (fifo_valid && fifo_ready) begin
                        for (int i = 0; i < FETCH_WIDTH; i++)
                            slot_d[i] = '0;
                        slot_d[0] = fifo_data;
                        if (eff_width == CNT_WIDTH'(1)) begin
                            state_d = HOLD;
                            pos_d   = '0;
                        end else begin
                            pos_d = CNT_WIDTH'(1);
                        end
                    end
`endif
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_comb begin
        receiver_data = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            receiver_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            width_q <= CNT_WIDTH'(1);
            pos_q   <= '0;
            for (int i = 0; i < FETCH_WIDTH; i++)
                slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            pos_q   <= pos_d;
            for (int i = 0; i < FETCH_WIDTH; i++)
                slot_q[i] <= slot_d[i];
        end
    end

endmodule

// File: tb/tb_fetch_width_aggregator.sv
// Scoreboard bench for fetch_width_aggregator: directed streams push expected groups,
// a negedge monitor pops and compares every receiver_enq.
module tb_fetch_width_aggregator;

    localparam int DW = 11;
    localparam int FW = 5;

    logic              clk;
    logic              rst_n;
    logic              fifo_valid;
    logic [DW-1:0]     fifo_data;
    logic              fifo_ready;
    logic              change_fetch_width;
    logic [2:0]        input_fetch_width;
    logic              receiver_full_n;
    logic              receiver_enq;
    logic [FW*DW-1:0]  receiver_data;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    logic [FW*DW-1:0] sb_q[$];
    int enq_cycles[$];

    fetch_width_aggregator #(
        .DATA_WIDTH  (DW),
        .FETCH_WIDTH (FW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fifo_valid         (fifo_valid),
        .fifo_data          (fifo_data),
        .fifo_ready         (fifo_ready),
        .change_fetch_width (change_fetch_width),
        .input_fetch_width  (input_fetch_width),
        .receiver_full_n    (receiver_full_n),
        .receiver_enq       (receiver_enq),
        .receiver_data      (receiver_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [FW*DW-1:0] grp(input int a, input int b, input int c,
                                             input int d, input int e);
        return {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every transfer must match the oldest expected group.
    always @(negedge clk) begin
        if (rst_n && receiver_enq) begin
            enq_cycles.push_back(cyc_cnt);
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_enq", 64'(receiver_data), 64'hdead);
            end else begin
                checkOutput("group_data", 64'(receiver_data), 64'(sb_q.pop_front()));
            end
        end
    end

    // Offer consecutive words with fifo_valid held high until count have been accepted.
    task automatic applyStimulus(input int first, input int count);
        int cur  = first;
        int sent = 0;
        int cyc  = 0;
        bit acc;
        fifo_valid = 1'b1;
        fifo_data  = DW'(cur);
        while (sent < count && cyc < 200) begin
            @(negedge clk);
            acc = fifo_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                cur++;
                fifo_data = DW'(cur);
            end
        end
        fifo_valid = 1'b0;
        if (sent < count)
            checkOutput("stream_timeout", 64'(sent), 64'(count));
    endtask

    task automatic setWidth(input int w);
        change_fetch_width = 1'b1;
        input_fetch_width  = 3'(w);
        @(posedge clk);
        #1;
        change_fetch_width = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectEnqNow(input string name);
        @(negedge clk);
        checkOutput(name, 64'(receiver_enq), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int period;
        int wait_cnt;
        rst_n              = 1'b0;
        fifo_valid         = 1'b0;
        fifo_data          = '0;
        change_fetch_width = 1'b0;
        input_fetch_width  = 3'd0;
        receiver_full_n    = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset_fifo_ready", 64'(fifo_ready), 64'd0);
        checkOutput("reset_enq", 64'(receiver_enq), 64'd0);
        checkOutput("reset_data", 64'(receiver_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Width 1 after reset: one-word groups and their cadence
`ifdef AGG_OVERLAP_EN
        period = 1;
`else
        period = 2;
`endif
        enq_cycles.delete();
        sb_q.push_back(grp(1, 0, 0, 0, 0));
        sb_q.push_back(grp(2, 0, 0, 0, 0));
        sb_q.push_back(grp(3, 0, 0, 0, 0));
        applyStimulus(1, 3);
        idle(3);
        checkOutput("w1_enq_count", 64'(enq_cycles.size()), 64'd3);
        if (enq_cycles.size() == 3) begin
            checkOutput("w1_period_a", 64'(enq_cycles[1] - enq_cycles[0]), 64'(period));
            checkOutput("w1_period_b", 64'(enq_cycles[2] - enq_cycles[1]), 64'(period));
        end

        // Width 5, two full groups
        setWidth(5);
        sb_q.push_back(grp(10, 11, 12, 13, 14));
        sb_q.push_back(grp(15, 16, 17, 18, 19));
        applyStimulus(10, 10);
        expectEnqNow("w5_latency");
        idle(2);

        // Width 4 under backpressure: data held, no dequeue
        setWidth(4);
        receiver_full_n = 1'b0;
        sb_q.push_back(grp(20, 21, 22, 23, 0));
        applyStimulus(20, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("bp_fifo_ready", 64'(fifo_ready), 64'd0);
            checkOutput("bp_enq", 64'(receiver_enq), 64'd0);
            checkOutput("bp_data", 64'(receiver_data), 64'(grp(20, 21, 22, 23, 0)));
            @(posedge clk);
            #1;
        end
        receiver_full_n = 1'b1;
        expectEnqNow("bp_release_enq");
        idle(1);

        // Width change mid-group discards the partial words
        setWidth(5);
        applyStimulus(30, 2);
        setWidth(4);
        sb_q.push_back(grp(40, 41, 42, 43, 0));
        applyStimulus(40, 4);
        expectEnqNow("discard_then_w4_enq");
        idle(2);

        // Width change coincident with a width-1 enq
        setWidth(1);
        sb_q.push_back(grp(7, 0, 0, 0, 0));
        applyStimulus(7, 1);
        change_fetch_width = 1'b1;
        input_fetch_width  = 3'd4;
        @(negedge clk);
        checkOutput("coincident_enq", 64'(receiver_enq), 64'd1);
        @(posedge clk);
        #1;
        change_fetch_width = 1'b0;
        sb_q.push_back(grp(50, 51, 52, 53, 0));
        applyStimulus(50, 4);
        expectEnqNow("after_change_w4_enq");
        idle(2);

        // Clamping: 0 behaves as 1, 7 behaves as 5
        setWidth(0);
        sb_q.push_back(grp(60, 0, 0, 0, 0));
        applyStimulus(60, 1);
        expectEnqNow("clamp0_enq");
        setWidth(7);
        sb_q.push_back(grp(70, 71, 72, 73, 74));
        applyStimulus(70, 5);
        expectEnqNow("clamp7_enq");
        idle(1);

        // Asynchronous reset in the middle of a group
        applyStimulus(80, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_fifo_ready", 64'(fifo_ready), 64'd0);
        checkOutput("midreset_enq", 64'(receiver_enq), 64'd0);
        checkOutput("midreset_data", 64'(receiver_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.push_back(grp(90, 0, 0, 0, 0));
        applyStimulus(90, 1);
        expectEnqNow("postreset_w1_enq");

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 50) begin
            @(posedge clk);
            wait_cnt++;
        end
        idle(2);
        checkOutput("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
